// File: rtl/counter_prescaled.sv
// Bounded up/down counter driven by a free-running prescaler tick.
// The prescaler divides the system clock by DIV and produces a one-cycle tick. On each
// tick the counter steps by one in the requested direction, either wrapping or saturating
// at the [MIN_VAL, MAX_VAL] bounds. A synchronous load writes a clamped value.
module counter_prescaled #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MIN_VAL = 1,
  parameter int unsigned MAX_VAL = 63,
  parameter int unsigned DIV     = 100000000,
  parameter int unsigned PSC_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cnt_en_i,
  input  logic             up_dn_i,
  input  logic             sat_mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tick_o,
  output logic             tc_o,
  output logic             at_max_o,
  output logic             at_min_o
);

  localparam logic [PSC_W-1:0] PscLast = PSC_W'(DIV - 1);
  localparam logic [WIDTH-1:0] MinV    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxV    = WIDTH'(MAX_VAL);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  logic             psc_wrap;
  logic             step;
  logic             at_max, at_min;
  logic [WIDTH-1:0] load_clamped;

  assign at_max = (cnt_q == MaxV);
  assign at_min = (cnt_q == MinV);

  // A step uses the tick registered on the previous edge; load always wins over a step.
  assign step = tick_q & cnt_en_i & ~load_i;

  // Prescaler next state: count 0..DIV-1 and flag the wrap as the next tick.
  always_comb begin
    psc_wrap = (psc_q == PscLast);
    psc_d    = psc_wrap ? '0 : psc_q + PSC_W'(1);
    tick_d   = psc_wrap;
  end

  // Clamp the load value into the legal counter range.
  always_comb begin
    load_clamped = load_val_i;
    if (load_val_i < MinV) begin
      load_clamped = MinV;
    end else if (load_val_i > MaxV) begin
      load_clamped = MaxV;
    end
  end

  // Counter next state: load > step > hold; tc flags a step taken at the active bound.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (load_i) begin
      cnt_d = load_clamped;
    end else if (step) begin
      if (up_dn_i) begin
        if (at_max) begin
          cnt_d = sat_mode_i ? MaxV : MinV;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          cnt_d = sat_mode_i ? MinV : MaxV;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      psc_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= MinV;
      tc_q   <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign tick_o   = tick_q;
  assign tc_o     = tc_q;
  assign at_max_o = at_max;
  assign at_min_o = at_min;

endmodule

// File: tb/tb_counter_prescaled.sv
// Bench for counter_prescaled: a DIV=4 and a DIV=1 instance share the same inputs and
// are compared every cycle against an arithmetic reference model of the counter rules.
module tb_counter_prescaled;

  localparam int W    = 6;
  localparam int MINV = 1;
  localparam int MAXV = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cnt_en = 1'b0;
  logic         up_dn = 1'b1;
  logic         sat_mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt4, cnt1;
  logic         tick4, tick1, tc4, tc1, amax4, amax1, amin4, amin1;

  int checks = 0;
  int errors = 0;

  // Reference model state: k = edges since the last reset edge.
  int k = 0;
  int m_cnt4 = MINV, m_cnt1 = MINV;
  bit m_tick4 = 0, m_tick1 = 0, m_tc4 = 0, m_tc1 = 0;

  always #5 clk = ~clk;

  counter_prescaled #(
    .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .DIV(4), .PSC_W(8)
  ) dut (
    .clk_i(clk), .reset_i(reset), .cnt_en_i(cnt_en), .up_dn_i(up_dn),
    .sat_mode_i(sat_mode), .load_i(load), .load_val_i(load_val),
    .cnt_o(cnt4), .tick_o(tick4), .tc_o(tc4), .at_max_o(amax4), .at_min_o(amin4)
  );

  counter_prescaled #(
    .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .DIV(1), .PSC_W(4)
  ) dut1 (
    .clk_i(clk), .reset_i(reset), .cnt_en_i(cnt_en), .up_dn_i(up_dn),
    .sat_mode_i(sat_mode), .load_i(load), .load_val_i(load_val),
    .cnt_o(cnt1), .tick_o(tick1), .tc_o(tc1), .at_max_o(amax1), .at_min_o(amin1)
  );

  function automatic int clamp(int v);
    if (v < MINV) return MINV;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  function automatic int step_val(int c, bit up, bit sat);
    if (up) return (c < MAXV) ? c + 1 : (sat ? MAXV : MINV);
    return (c > MINV) ? c - 1 : (sat ? MINV : MAXV);
  endfunction

  function automatic bit at_bound(int c, bit up);
    return up ? (c == MAXV) : (c == MINV);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  // Advance the model for one counter instance given its tick from the previous edge.
  task automatic model_inst(input bit tick_prev, inout int c, inout bit tc);
    if (load) begin
      c  = clamp(int'(load_val));
      tc = 0;
    end else if (tick_prev && cnt_en) begin
      tc = at_bound(c, up_dn);
      c  = step_val(c, up_dn, sat_mode);
    end else begin
      tc = 0;
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e4, e1;
    e4 = W'(m_cnt4);
    e1 = W'(m_cnt1);
    check("cnt_div4", 8'(cnt4), 8'(e4));
    check("tick_div4", 8'(tick4), 8'(m_tick4));
    check("tc_div4", 8'(tc4), 8'(m_tc4));
    check("at_max_div4", 8'(amax4), 8'(m_cnt4 == MAXV));
    check("at_min_div4", 8'(amin4), 8'(m_cnt4 == MINV));
    check("cnt_div1", 8'(cnt1), 8'(e1));
    check("tick_div1", 8'(tick1), 8'(m_tick1));
    check("tc_div1", 8'(tc1), 8'(m_tc1));
    check("at_max_div1", 8'(amax1), 8'(m_cnt1 == MAXV));
    check("at_min_div1", 8'(amin1), 8'(m_cnt1 == MINV));
  endtask

  // One clock: update model at the edge using the inputs held across it, then compare.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      k = 0;
      m_cnt4 = MINV; m_cnt1 = MINV;
      m_tick4 = 0; m_tick1 = 0; m_tc4 = 0; m_tc1 = 0;
    end else begin
      model_inst(m_tick4, m_cnt4, m_tc4);
      model_inst(m_tick1, m_cnt1, m_tc1);
      k++;
      m_tick4 = (k % 4 == 0);
      m_tick1 = (k % 1 == 0);
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the DIV=4 tick is visible, bounded to two periods.
  task automatic wait_tick4();
    int n;
    n = 0;
    while (tick4 !== 1'b1 && n < 8) begin
      cycle();
      n++;
    end
    check("tick4_found", 8'(tick4), 8'd1);
  endtask

  initial begin
    // 1: reset for three cycles, then free run with counting disabled.
    reset = 1'b1;
    run(3);
    check("reset_cnt", 8'(cnt4), 8'd1);
    check("reset_at_min", 8'(amin4), 8'd1);
    reset = 1'b0;
    run(13);

    // 2: wrap counting upward.
    cnt_en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    run(26);

    // 3: saturate up at MAX, then count down to MIN and hold there.
    sat_mode = 1'b1;
    run(24);
    up_dn = 1'b0;
    run(28);

    // 4: wrap downward from MIN, then freeze counting for three ticks.
    sat_mode = 1'b0;
    run(8);
    cnt_en = 1'b0;
    run(12);
    cnt_en = 1'b1;

    // 5: clamped loads, and a load coinciding with a tick.
    load = 1'b1; load_val = 6'd9;
    cycle();
    check("load_hi_clamp", 8'(cnt4), 8'd5);
    load_val = 6'd0;
    cycle();
    check("load_lo_clamp", 8'(cnt4), 8'd1);
    load = 1'b0;
    wait_tick4();
    load = 1'b1; load_val = 6'd3;
    cycle();
    load = 1'b0;
    check("load_on_tick_cnt", 8'(cnt4), 8'd3);
    check("load_on_tick_tc", 8'(tc4), 8'd0);

    // 6: reset on a tick edge with cnt=3, then observe the restart spacing.
    run(2);
    wait_tick4();
    cnt_en = 1'b0;
    load = 1'b1; load_val = 6'd3;
    cycle();
    load = 1'b0;
    wait_tick4();
    reset = 1'b1;
    cycle();
    check("mid_reset_cnt", 8'(cnt4), 8'd1);
    reset = 1'b0;
    cnt_en = 1'b1; up_dn = 1'b1;
    run(12);

    // Randomised phase: mostly counting, occasional loads, mode flips and resets.
    for (int i = 0; i < 2000; i++) begin
      cnt_en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 15) == 0) sat_mode = ~sat_mode;
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom_range(0, 63));
      reset    = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    load = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
